// File: rtl/store_buffer_pkg.sv
// Shared definitions for the posted-write store buffer: entry layout,
// default depth and the memory-port grant encoding.
package store_buffer_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ENTRY_W       = 68;
  localparam int ADDR_LSB         = 36;
  localparam int DATA_LSB         = 4;
  localparam int MASK_LSB         = 0;

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_LOAD,
    GRANT_DRAIN
  } grant_e;

  function automatic logic [SB_ENTRY_W-1:0] sb_pack(
    input logic [31:0] addr,
    input logic [31:0] data,
    input logic [3:0]  mask
  );
    return {addr, data, mask};
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Synchronous FIFO holding buffered stores; publishes every slot's word
// address and a valid bit so the parent can compare loads against them.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [SB_ENTRY_W-1:0] i_entry,
  output logic [SB_ENTRY_W-1:0] o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH*30-1:0]   o_word_addrs,
  output logic [DEPTH-1:0]      o_valid
);

  logic [SB_ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W:0]        r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; validity comes from the
  // pointers and count, so slot contents after reset are irrelevant.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // A slot is live when its distance from the head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] w_off;
    assign w_off                     = PTR_W'(g) - r_rd_ptr;
    assign o_valid[g]                = ({1'b0, w_off} < r_count);
    assign o_word_addrs[g*30 +: 30]  = r_mem[g][ADDR_LSB+2 +: 30];
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between the MEM stage and data memory: stores queue
// and drain when the port is free, loads bypass unless they hit a pending word.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_write_data,
  input  logic        cpu_memwrite,
  input  logic        cpu_memread,
  input  logic [3:0]  cpu_sign_mask,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic        mem_clk_stall,
  output logic        empty
);

  logic [SB_ENTRY_W-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [DEPTH*30-1:0]   w_word_addrs;
  logic [DEPTH-1:0]      w_valid;
  logic                  w_hit;
  logic                  w_push;
  logic                  w_pop;
  grant_e                w_grant;

  sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_entry      (sb_pack(cpu_addr, cpu_write_data, cpu_sign_mask)),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_word_addrs (w_word_addrs),
    .o_valid      (w_valid)
  );

  // NOTE: every always_comb output gets a default first so no path
  // leaves it unassigned and a latch is never inferred.
  always_comb begin
    w_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_word_addrs[i*30 +: 30] == cpu_addr[31:2])) w_hit = 1'b1;
    end
  end

  // Loads win the port; a hitting load yields so the conflicting store drains.
  always_comb begin
    w_grant = GRANT_IDLE;
    if (!reset) begin
      if (cpu_memread && !w_hit)           w_grant = GRANT_LOAD;
      else if (!w_empty && !mem_clk_stall) w_grant = GRANT_DRAIN;
    end
  end

  // A full buffer refuses the store even if a pop happens the same cycle.
  assign w_push    = !reset && cpu_memwrite && !w_full;
  assign w_pop     = (w_grant == GRANT_DRAIN);
  assign cpu_stall = !reset && ((cpu_memwrite && w_full) || (cpu_memread && w_hit));

  assign mem_memread    = (w_grant == GRANT_LOAD);
  assign mem_memwrite   = (w_grant == GRANT_DRAIN);
  assign mem_addr       = mem_memread ? cpu_addr      : w_head[ADDR_LSB +: 32];
  assign mem_sign_mask  = mem_memread ? cpu_sign_mask : w_head[MASK_LSB +: 4];
  assign mem_write_data = w_head[DATA_LSB +: 32];
  assign empty          = w_empty;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the MEM-stage load/store signals and the data memory.
- Stores retire into a small FIFO without stalling the pipeline. They drain to the data memory one per cycle whenever the memory port is free.
- Loads bypass the FIFO straight to the memory. A load stalls only when it hits a pending store to the same word; that keeps load data coherent without forwarding.
- Read data returns directly from the data memory to the pipeline; it does not pass through this block.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- PTR_W, 2, log2(DEPTH), the FIFO pointer width.

Ports:
- clk  in  1  system clock; all state changes on the posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_addr  in  32  byte address from the MEM stage.
- cpu_write_data  in  32  store data, unshifted.
- cpu_memwrite  in  1  store request.
- cpu_memread  in  1  load request; never asserted in the same cycle as cpu_memwrite.
- cpu_sign_mask  in  4  sign/width mask: [3] sign-extend, [2] word, [1] half, [0] byte.
- cpu_stall  out  1  holds the MEM stage; the request is not accepted this cycle.
- mem_addr  out  32  address to the data memory.
- mem_write_data  out  32  store data to the data memory.
- mem_memwrite  out  1  write strobe to the data memory.
- mem_memread  out  1  read strobe to the data memory.
- mem_sign_mask  out  4  sign/width mask to the data memory.
- mem_clk_stall  in  1  data memory busy (read in progress); no write may be presented.
- empty  out  1  no valid entries; used for fence and debug.

Behaviour:
- State:
  - FIFO of DEPTH entries. Each entry is {addr[31:0], data[31:0], mask[3:0]}.
  - Registers: wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (0..DEPTH).
  - full = (count==DEPTH); empty = (count==0).
- Reset: wr_ptr, rd_ptr and count go to 0. Entry contents are don't-care. While reset is high, cpu_stall, mem_memwrite and mem_memread are forced to 0.
- hit: asserted when any valid entry has addr[31:2] == cpu_addr[31:2].
  - Word granularity; byte offset and mask are ignored, so partial-word overlap is treated conservatively.
- cpu_stall = (cpu_memwrite & full) | (cpu_memread & hit). This is combinational from registered state and the cpu inputs.
- Port arbitration, one grant per cycle:
  1. LOAD_PASS, when cpu_memread & ~hit:
     - mem_memread=1, mem_memwrite=0.
     - mem_addr and mem_sign_mask come from the cpu inputs.
     - This is unconditional on mem_clk_stall; the data memory ignores inputs while busy.
  2. DRAIN, when ~LOAD_PASS & ~empty & ~mem_clk_stall:
     - mem_memwrite=1, mem_memread=0.
     - mem_addr, mem_write_data and mem_sign_mask come from the head entry.
     - rd_ptr increments at the posedge.
  3. IDLE, otherwise:
     - mem_memwrite=0, mem_memread=0.
     - mem_addr, mem_write_data and mem_sign_mask show the head entry (don't-care).
- Push: when cpu_memwrite & ~full, the entry is written at wr_ptr and wr_ptr increments at the posedge.
  - A full buffer never accepts a store, even if a drain pops in the same cycle. The store is accepted the following cycle.
- Count update:
  - Push and pop in the same cycle: count unchanged.
  - Push only: count+1.
  - Pop only: count-1.
- Latency:
  - An accepted store appears as mem_memwrite no earlier than the next cycle.
  - With an empty buffer and no competing loads, the store reaches memory exactly 1 cycle after acceptance.
- Load hit: the pipeline holds the load. Drains continue, and DRAIN wins arbitration because LOAD_PASS is false. The load issues in the first cycle in which hit is false.
- Ordering:
  - Stores drain in program order.
  - A load never overtakes a store to the same word.
  - A load may overtake stores to other words.
  - MMIO stores (LED at 0x2000) are buffered like any other store.
- mem_clk_stall high: no drain, and no entry is lost. A push still occurs if the buffer is not full.
- Reset mid-operation: pending stores are discarded. No partial write is issued after reset asserts.

Decomposition:
- Shared package: SB_ENTRY_W=68, field offsets (ADDR_LSB=36, DATA_LSB=4, MASK_LSB=0), and the default DEPTH.
- One natural sub-module, sb_fifo: a synchronous FIFO holding the storage, pointers, count, full and empty.
  - It exposes all entry addresses in parallel for the hit compare.
- Arbitration and hit logic stay in store_buffer.

Test Plan:
- Reset then a single sw (cpu_addr=0x1004, data=0xDEADBEEF, mask=0100) -> cpu_stall=0; the next cycle shows mem_memwrite=1, mem_addr=0x1004, mem_write_data=0xDEADBEEF; empty=1 after that.
- Five back-to-back stores with mem_clk_stall=1 -> the first four are accepted; the fifth sees cpu_stall=1 until mem_clk_stall drops. Drains then occur in order, and the fifth is accepted the cycle after the first pop.
- sb to 0x1001 pending, then lw 0x1000 -> cpu_stall=1 and mem_memread=0 until the 0x1001 write drains. mem_memread=1 with mem_addr=0x1000 follows on the next cycle.
- Stores to 0x1010 pending, then lw 0x1020 -> no stall; mem_memread=1 the same cycle with the drain deferred. The drain resumes the next cycle.
- sw to 0x2000 with data=0x5A -> exactly one mem_memwrite with mem_addr=0x2000 and mem_write_data=0x5A.
- Three stores buffered, reset asserted for 1 cycle -> empty=1 and no mem_memwrite during or after reset.
